// File: rtl/line_window_buffer.sv
// line_window_buffer
//   Line-buffer front end for the spatial-filter pipeline. It holds
//   KERNEL+1 image lines and presents KERNELxKERNEL pixel windows to the
//   downstream convolution stage. Zero edge padding is optional. One line
//   is released per row of windows, and o_intr pulses so that the DMA/CPU
//   can push the next line.
//
//   Handshake semantics (both sides): a transfer happens on a rising edge
//   where valid && ready. A producer holding valid keeps its payload stable
//   until the transfer. Ready may depend on registered state only.
//
// Ports
//   axi_clk, axi_reset  clock, asynchronous active-high reset
//   i_data_valid/i_data pixel stream in raster order
//   o_data_ready        high while a buffer is free (fill < KERNEL+1)
//   i_pad_en            zero-pad mode, captured on each IDLE->RUN
//   o_win_valid/o_win   registered window, element (r,k) at
//                       [(r*KERNEL+k)*DATA_W +: DATA_W], r=0 oldest line
//   i_win_ready         downstream accepts the window
//   o_intr              one-cycle pulse per released line
//   o_fill_lines        complete lines held and not yet released
module line_window_buffer #(
    parameter int DATA_W    = 8,
    parameter int IMG_WIDTH = 512,
    parameter int KERNEL    = 3
) (
    input  logic                              axi_clk,
    input  logic                              axi_reset,
    input  logic                              i_data_valid,
    input  logic [DATA_W-1:0]                 i_data,
    output logic                              o_data_ready,
    input  logic                              i_pad_en,
    output logic                              o_win_valid,
    output logic [KERNEL*KERNEL*DATA_W-1:0]   o_win,
    input  logic                              i_win_ready,
    output logic                              o_intr,
    output logic [$clog2(KERNEL+2)-1:0]       o_fill_lines
);

    localparam int NUM_BUF = KERNEL + 1;
    localparam int BUF_W   = $clog2(NUM_BUF);
    localparam int COL_W   = $clog2(IMG_WIDTH);
    localparam int CNT_W   = $clog2(IMG_WIDTH + 1);
    localparam int FILL_W  = $clog2(KERNEL + 2);
    localparam int HALF    = KERNEL / 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } stateT;

    stateT state;
    stateT stateNext;

    logic [DATA_W-1:0] lineMem [NUM_BUF][IMG_WIDTH];

    logic [COL_W-1:0]  wrCol;
    logic [BUF_W-1:0]  wrBuf;
    logic [FILL_W-1:0] fill;
    logic              wrFire;
    logic              lineDone;

    logic [CNT_W-1:0]  rdCol;
    logic [BUF_W-1:0]  rdBase;
    logic              pad;
    logic [CNT_W-1:0]  winPerLine;
    logic              accept;
    logic              loadWin;
    logic              startRun;
    logic              lineRelease;
    logic [KERNEL*KERNEL*DATA_W-1:0] winNext;

    // ---------------- write side ----------------
    assign o_data_ready = (fill < FILL_W'(NUM_BUF));
    assign o_fill_lines = fill;
    assign wrFire       = i_data_valid && o_data_ready;
    assign lineDone     = wrFire && (wrCol == COL_W'(IMG_WIDTH - 1));

    // Pixel storage carries no reset; its contents only matter once a
    // line has been completely written.
    always_ff @(posedge axi_clk) begin
        if (wrFire) begin
            lineMem[wrBuf][wrCol] <= i_data;
        end
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            wrCol <= '0;
            wrBuf <= '0;
            fill  <= '0;
        end else begin
            if (wrFire) begin
                if (lineDone) begin
                    wrCol <= '0;
                    wrBuf <= (wrBuf == BUF_W'(NUM_BUF - 1)) ? '0 : wrBuf + BUF_W'(1);
                end else begin
                    wrCol <= wrCol + COL_W'(1);
                end
            end
            // A completion and a release in the same cycle cancel out.
            case ({lineDone, lineRelease})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    // ---------------- read FSM ----------------
    assign winPerLine = pad ? CNT_W'(IMG_WIDTH) : CNT_W'(IMG_WIDTH - KERNEL + 1);
    assign accept     = o_win_valid && i_win_ready;
    assign o_intr     = lineRelease;

    always_comb begin
        stateNext   = state;
        loadWin     = 1'b0;
        startRun    = 1'b0;
        lineRelease = 1'b0;
        case (state)
            IDLE: begin
                if (fill >= FILL_W'(KERNEL)) begin
                    stateNext = RUN;
                    startRun  = 1'b1;
                end
            end
            RUN: begin
                // Output register is free when empty or being drained now.
                if ((!o_win_valid || i_win_ready) && (rdCol < winPerLine)) begin
                    loadWin = 1'b1;
                end
                // rdCol == winPerLine means the last window is already in
                // the output register; its acceptance ends the line.
                if (accept && (rdCol == winPerLine)) begin
                    stateNext = RELEASE;
                end
            end
            RELEASE: begin
                lineRelease = 1'b1;
                stateNext   = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Gather window rdCol from the KERNEL lines starting at rdBase. Columns
    // that fall outside the line (pad mode only) read as zero.
    always_comb begin
        int bufIdx;
        int colIdx;
        bufIdx  = 0;
        colIdx  = 0;
        winNext = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int k = 0; k < KERNEL; k++) begin
                bufIdx = int'(rdBase) + r;
                if (bufIdx >= NUM_BUF) begin
                    bufIdx = bufIdx - NUM_BUF;
                end
                colIdx = int'(rdCol) + k - (pad ? HALF : 0);
                if ((colIdx >= 0) && (colIdx < IMG_WIDTH)) begin
                    winNext[(r*KERNEL+k)*DATA_W +: DATA_W] =
                        lineMem[BUF_W'(bufIdx)][COL_W'(colIdx)];
                end
            end
        end
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state       <= IDLE;
            rdCol       <= '0;
            rdBase      <= '0;
            pad         <= 1'b0;
            o_win_valid <= 1'b0;
            o_win       <= '0;
        end else begin
            state <= stateNext;
            if (startRun) begin
                rdCol <= '0;
                pad   <= i_pad_en;
            end else if (loadWin) begin
                rdCol <= rdCol + CNT_W'(1);
            end
            if (lineRelease) begin
                rdBase <= (rdBase == BUF_W'(NUM_BUF - 1)) ? '0 : rdBase + BUF_W'(1);
            end
            if (loadWin) begin
                o_win_valid <= 1'b1;
                o_win       <= winNext;
            end else if (accept) begin
                o_win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer (IMG_WIDTH=8, KERNEL=3).
// Pixel value = row*16 + col. Inputs change 1 time unit after the rising
// edge; a negedge monitor records every accepted window and each o_intr.
module tb_line_window_buffer;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int K  = 3;
    localparam int WW = K * K * DW;

    logic          axi_clk      = 1'b0;
    logic          axi_reset    = 1'b1;
    logic          i_data_valid = 1'b0;
    logic [DW-1:0] i_data       = '0;
    logic          i_pad_en     = 1'b0;
    logic          i_win_ready  = 1'b0;
    logic          o_data_ready;
    logic          o_win_valid;
    logic [WW-1:0] o_win;
    logic          o_intr;
    logic [2:0]    o_fill_lines;

    line_window_buffer #(
        .DATA_W   (DW),
        .IMG_WIDTH(IW),
        .KERNEL   (K)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_reset   (axi_reset),
        .i_data_valid(i_data_valid),
        .i_data      (i_data),
        .o_data_ready(o_data_ready),
        .i_pad_en    (i_pad_en),
        .o_win_valid (o_win_valid),
        .o_win       (o_win),
        .i_win_ready (i_win_ready),
        .o_intr      (o_intr),
        .o_fill_lines(o_fill_lines)
    );

    // ---------------- clock ----------------
    always #5 axi_clk = ~axi_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int intrCount  = 0;
    int lastAccCyc = 0;
    int intrGap    = 0;
    int intrFill   = 0;
    logic [WW-1:0] gotQ[$];
    logic [WW-1:0] expQ[$];

    always @(posedge axi_clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge axi_clk) begin
        if (!axi_reset) begin
            if (o_win_valid && i_win_ready) begin
                gotQ.push_back(o_win);
                lastAccCyc = cyc;
            end
            if (o_intr) begin
                intrCount++;
                intrGap  = cyc - lastAccCyc;
                intrFill = int'(o_fill_lines);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] expWin(input int row0, input int c, input bit padOn);
        logic [WW-1:0] w;
        int col;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int k = 0; k < K; k++) begin
                col = c + k - (padOn ? 1 : 0);
                if (col >= 0 && col < IW) w[(r*K+k)*DW +: DW] = DW'((row0 + r) * 16 + col);
            end
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic doReset();
        axi_reset    = 1'b1;
        i_data_valid = 1'b0;
        repeat (3) tick();
        axi_reset = 1'b0;
        gotQ.delete();
        expQ.delete();
        intrCount = 0;
    endtask

    task automatic sendPixel(input logic [DW-1:0] d);
        int n;
        n = 0;
        i_data_valid = 1'b1;
        i_data       = d;
        @(negedge axi_clk);
        while (!o_data_ready && n < 200) begin
            @(negedge axi_clk);
            n++;
        end
        if (n >= 200) check("timeout_pixel", 0, 1);
        tick();
        i_data_valid = 1'b0;
    endtask

    task automatic writeRow(input int row);
        for (int c = 0; c < IW; c++) sendPixel(DW'(row * 16 + c));
    endtask

    task automatic waitWindows(input int n);
        int t;
        t = 0;
        while (gotQ.size() < n && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) check("timeout_windows", WW'(gotQ.size()), WW'(n));
    endtask

    task automatic waitIntr(input int n);
        int t;
        t = 0;
        while (intrCount < n && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) check("timeout_intr", WW'(intrCount), WW'(n));
    endtask

    task automatic addExp(input int row0, input bit padOn, input int n);
        for (int c = 0; c < n; c++) expQ.push_back(expWin(row0, c, padOn));
    endtask

    task automatic compareAll(input string tag);
        check({tag, "_count"}, WW'(gotQ.size()), WW'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            check($sformatf("%s_win%0d", tag, i), gotQ[i], expQ[i]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset values
        doReset();
        check("rst_ready", WW'(o_data_ready), 1);
        check("rst_valid", WW'(o_win_valid), 0);
        check("rst_intr",  WW'(o_intr), 0);
        check("rst_fill",  WW'(o_fill_lines), 0);
        check("rst_win",   o_win, '0);

        // no pad, rows 0..2, free-running downstream
        i_pad_en    = 1'b0;
        i_win_ready = 1'b1;
        for (int r = 0; r < 3; r++) writeRow(r);
        waitIntr(1);
        check("np_intr_gap",  WW'(intrGap), 1);
        check("np_fill_at_intr", WW'(intrFill), 3);
        repeat (5) tick();
        check("np_intr_once", WW'(intrCount), 1);
        check("np_fill_after", WW'(o_fill_lines), 2);
        check("np_valid_low", WW'(o_win_valid), 0);
        addExp(0, 1'b0, 6);
        compareAll("np");
        check("np_first", gotQ[0], 72'h222120121110020100);
        check("np_last",  gotQ[5], 72'h272625171615070605);

        // pad on, same rows
        doReset();
        i_pad_en    = 1'b1;
        i_win_ready = 1'b1;
        for (int r = 0; r < 3; r++) writeRow(r);
        waitIntr(1);
        repeat (5) tick();
        check("pad_intr_once", WW'(intrCount), 1);
        addExp(0, 1'b1, 8);
        compareAll("pad");
        check("pad_first", gotQ[0], 72'h212000111000010000);
        check("pad_last",  gotQ[7], 72'h002726001716000706);

        // backpressure: stall 5 cycles while window 2 is presented
        doReset();
        i_pad_en    = 1'b0;
        i_win_ready = 1'b1;
        for (int r = 0; r < 3; r++) writeRow(r);
        waitWindows(2);
        i_win_ready = 1'b0;
        check("bp_hold_valid0", WW'(o_win_valid), 1);
        check("bp_hold_win0", o_win, expWin(0, 2, 1'b0));
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), WW'(o_win_valid), 1);
            check($sformatf("bp_hold_win%0d", i), o_win, expWin(0, 2, 1'b0));
        end
        i_win_ready = 1'b1;
        waitIntr(1);
        addExp(0, 1'b0, 6);
        compareAll("bp");

        // full: four rows with downstream stalled
        doReset();
        i_pad_en    = 1'b0;
        i_win_ready = 1'b0;
        for (int r = 0; r < 4; r++) writeRow(r);
        check("full_ready", WW'(o_data_ready), 0);
        check("full_fill",  WW'(o_fill_lines), 4);
        i_data_valid = 1'b1;
        i_data       = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("full_ignore_ready%0d", i), WW'(o_data_ready), 0);
            check($sformatf("full_ignore_fill%0d", i),  WW'(o_fill_lines), 4);
        end
        i_data_valid = 1'b0;
        i_win_ready  = 1'b1;
        waitIntr(1);
        check("full_rel_ready", WW'(o_data_ready), 1);
        check("full_rel_fill",  WW'(o_fill_lines), 3);
        writeRow(4);
        waitIntr(3);
        repeat (5) tick();
        check("full_fill_end", WW'(o_fill_lines), 2);
        addExp(0, 1'b0, 6);
        addExp(1, 1'b0, 6);
        addExp(2, 1'b0, 6);
        compareAll("full");

        // asynchronous reset while window 3 is presented
        doReset();
        i_pad_en    = 1'b0;
        i_win_ready = 1'b1;
        for (int r = 0; r < 3; r++) writeRow(r);
        waitWindows(3);
        axi_reset = 1'b1;
        #1;
        check("arst_valid", WW'(o_win_valid), 0);
        check("arst_intr",  WW'(o_intr), 0);
        check("arst_win",   o_win, '0);
        check("arst_fill",  WW'(o_fill_lines), 0);
        check("arst_ready", WW'(o_data_ready), 1);
        repeat (2) tick();
        axi_reset = 1'b0;
        gotQ.delete();
        expQ.delete();
        intrCount = 0;
        for (int r = 0; r < 3; r++) writeRow(r);
        waitIntr(1);
        check("arst_intr_gap", WW'(intrGap), 1);
        check("arst_fill_at_intr", WW'(intrFill), 3);
        repeat (5) tick();
        check("arst_intr_once", WW'(intrCount), 1);
        addExp(0, 1'b0, 6);
        compareAll("arst");
        check("arst_first", gotQ[0], 72'h222120121110020100);
        check("arst_last",  gotQ[5], 72'h272625171615070605);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
